// File: rtl/ring_pkg.sv
// Shared encodings for the ring counter phase monitor and its helpers.
package ring_pkg;

  localparam logic [1:0] SEEK  = 2'd0;
  localparam logic [1:0] LOCK  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NOT_OH = 2'b01;
  localparam logic [1:0] ERR_JUMP   = 2'b10;

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary index of a ring vector.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         ring,
  output logic                     oh,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IW = $clog2(WIDTH);

  logic seen;
  logic multi;

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths that skip an assignment infer latches.
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = IW'(i);
      end
    end
    oh = seen & ~multi;
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot ring counter: phase decode, revolution count, stall and fault detection.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIR       = 0,
  parameter int REV_W     = 8,
  parameter int STALL_MAX = 15
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         ring,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     locked,
  output logic                     rev_pulse,
  output logic [REV_W-1:0]         rev_cnt,
  output logic                     stall,
  output logic                     fault,
  output logic [1:0]               err_code
);

  localparam int PW  = $clog2(WIDTH);
  localparam int SCW = $clog2(STALL_MAX + 1);

  localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_MAX);
  // Phase whose legal successor closes a revolution.
  localparam logic [PW-1:0]  WRAP_PH   = (DIR == 0) ? PW'(WIDTH - 1) : '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rot_prev;
  logic             oh;
  logic [PW-1:0]    idx;
  logic [SCW-1:0]   stall_cnt;
  logic [SCW-1:0]   stall_inc;

  ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .ring (ring),
    .oh   (oh),
    .idx  (idx)
  );

  if (DIR == 0) begin : g_rot_up
    assign rot_prev = {prev[WIDTH-2:0], prev[WIDTH-1]};
  end else begin : g_rot_down
    assign rot_prev = {prev[0], prev[WIDTH-1:1]};
  end

  always_comb begin
    stall_inc = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= SEEK;
      prev      <= '0;
      phase     <= '0;
      locked    <= 1'b0;
      rev_pulse <= 1'b0;
      rev_cnt   <= '0;
      stall_cnt <= '0;
      stall     <= 1'b0;
      fault     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
      rev_pulse <= 1'b0;
      case (state)
        SEEK: begin
          // Zero and multi-hot values are normal while the counter starts up.
          if (oh) begin
            prev      <= ring;
            phase     <= idx;
            locked    <= 1'b1;
            stall_cnt <= '0;
            stall     <= 1'b0;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (ring == prev) begin
            stall_cnt <= stall_inc;
            stall     <= (stall_inc == STALL_LIM);
          end else if (ring == rot_prev) begin
            prev      <= ring;
            phase     <= idx;
            stall_cnt <= '0;
            stall     <= 1'b0;
            if (phase == WRAP_PH) begin
              rev_cnt   <= rev_cnt + 1'b1;
              rev_pulse <= 1'b1;
            end
          end else begin
            state     <= FAULT;
            locked    <= 1'b0;
            fault     <= 1'b1;
            stall     <= 1'b0;
            stall_cnt <= '0;
            err_code  <= oh ? ERR_JUMP : ERR_NOT_OH;
          end
        end
        FAULT: begin
          if (err_clr) begin
            fault    <= 1'b0;
            err_code <= ERR_NONE;
            state    <= SEEK;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized and directed bench for ring_phase_monitor, one instance per rotation direction.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] ring0, ring1;
  logic       ec0, ec1;

  logic [1:0] phase0, phase1;
  logic       locked0, locked1, pulse0, pulse1, stall0, stall1, fault0, fault1;
  logic [7:0] rev0, rev1;
  logic [1:0] code0, code1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = upward rotation, 1 = downward rotation.
  int m_phase[2], m_code[2], m_rev[2], m_holds[2];
  bit m_locked[2], m_fault[2], m_pulse[2], m_stall[2];
  logic [3:0] last[2];

  always #5 clk = ~clk;

  ring_phase_monitor #(.WIDTH(4), .DIR(0), .REV_W(8), .STALL_MAX(15)) dut0 (
    .clk(clk), .clr(clr), .ring(ring0), .err_clr(ec0),
    .phase(phase0), .locked(locked0), .rev_pulse(pulse0), .rev_cnt(rev0),
    .stall(stall0), .fault(fault0), .err_code(code0)
  );

  ring_phase_monitor #(.WIDTH(4), .DIR(1), .REV_W(8), .STALL_MAX(15)) dut1 (
    .clk(clk), .clr(clr), .ring(ring1), .err_clr(ec1),
    .phase(phase1), .locked(locked1), .rev_pulse(pulse1), .rev_cnt(rev1),
    .stall(stall1), .fault(fault1), .err_code(code1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_code[k] = 0; m_rev[k] = 0; m_holds[k] = 0;
      m_locked[k] = 0; m_fault[k] = 0; m_pulse[k] = 0; m_stall[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r, input logic e);
    int ones;
    int ix;
    int nxt;
    ones = $countones(r);
    ix = 0;
    for (int i = 0; i < 4; i++) if (r[i]) ix = i;
    nxt = (k == 1) ? (m_phase[k] + 3) % 4 : (m_phase[k] + 1) % 4;
    m_pulse[k] = 0;
    if (m_fault[k]) begin
      if (e) begin
        m_fault[k] = 0;
        m_code[k]  = 0;
      end
    end else if (!m_locked[k]) begin
      if (ones == 1) begin
        m_locked[k] = 1; m_phase[k] = ix; m_holds[k] = 0; m_stall[k] = 0;
      end
    end else if (ones == 1 && ix == m_phase[k]) begin
      m_holds[k] = (m_holds[k] < 15) ? m_holds[k] + 1 : 15;
      m_stall[k] = (m_holds[k] == 15);
    end else if (ones == 1 && ix == nxt) begin
      if (nxt == ((k == 1) ? 3 : 0)) begin
        m_rev[k]   = (m_rev[k] + 1) % 256;
        m_pulse[k] = 1;
      end
      m_phase[k] = ix; m_holds[k] = 0; m_stall[k] = 0;
    end else begin
      m_locked[k] = 0; m_fault[k] = 1; m_stall[k] = 0; m_holds[k] = 0;
      m_code[k] = (ones == 1) ? 2 : 1;
    end
  endtask

  task automatic check_all();
    check("d0.phase",  32'(phase0),  32'(m_phase[0]));
    check("d0.locked", 32'(locked0), 32'(m_locked[0]));
    check("d0.pulse",  32'(pulse0),  32'(m_pulse[0]));
    check("d0.revcnt", 32'(rev0),    32'(m_rev[0]));
    check("d0.stall",  32'(stall0),  32'(m_stall[0]));
    check("d0.fault",  32'(fault0),  32'(m_fault[0]));
    check("d0.code",   32'(code0),   32'(m_code[0]));
    check("d1.phase",  32'(phase1),  32'(m_phase[1]));
    check("d1.locked", 32'(locked1), 32'(m_locked[1]));
    check("d1.pulse",  32'(pulse1),  32'(m_pulse[1]));
    check("d1.revcnt", 32'(rev1),    32'(m_rev[1]));
    check("d1.stall",  32'(stall1),  32'(m_stall[1]));
    check("d1.fault",  32'(fault1),  32'(m_fault[1]));
    check("d1.code",   32'(code1),   32'(m_code[1]));
  endtask

  // Starts and ends on a falling edge; inputs are applied there and outputs checked 1 ns after the rising edge.
  task automatic cycle(input logic [3:0] r0, input logic e0, input logic [3:0] r1, input logic e1);
    ring0 = r0; ec0 = e0; ring1 = r1; ec1 = e1;
    last[0] = r0; last[1] = r1;
    @(posedge clk);
    model_step(0, r0, e0);
    model_step(1, r1, e1);
    #1 check_all();
    @(negedge clk);
  endtask

  function automatic logic [3:0] gen(input logic [3:0] prior, input int k);
    int sel;
    int ix;
    logic [3:0] v;
    sel = int'($urandom_range(99));
    ix = 0;
    for (int i = 0; i < 4; i++) if (prior[i]) ix = i;
    if (sel < 60) begin
      if ($countones(prior) == 1) v = 4'(1 << ((k == 1) ? (ix + 3) % 4 : (ix + 1) % 4));
      else v = 4'(1 << $urandom_range(3));
    end else if (sel < 85) v = prior;
    else if (sel < 93) v = 4'(1 << $urandom_range(3));
    else v = 4'($urandom_range(15));
    return v;
  endfunction

  function automatic logic rnd_clr();
    return ($urandom_range(3) == 0);
  endfunction

  // Upward-rotating instance takes a directed value; the other gets random traffic.
  task automatic drive0(input logic [3:0] r0, input logic e0);
    cycle(r0, e0, gen(last[1], 1), rnd_clr());
  endtask

  initial begin
    logic [3:0] up_seq[5];
    logic [3:0] dn_seq[5];
    up_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dn_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

    clr = 1'b0; ring0 = '0; ring1 = '0; ec0 = 1'b0; ec1 = 1'b0;
    last[0] = '0; last[1] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    clr = 1'b1;

    // Basic lock and one revolution in each direction.
    for (int i = 0; i < 5; i++) cycle(up_seq[i], 1'b0, dn_seq[i], 1'b0);

    // Not-one-hot fault while at phase 1, then acknowledge with the bad value still present.
    drive0(4'b0010, 1'b0);
    drive0(4'b0110, 1'b0);
    drive0(4'b0110, 1'b0);
    drive0(4'b0110, 1'b1);
    drive0(4'b0000, 1'b0);

    // Skip and reverse jumps from phase 0.
    drive0(4'b0001, 1'b1);
    drive0(4'b0100, 1'b0);
    drive0(4'b0100, 1'b1);
    drive0(4'b0001, 1'b0);
    drive0(4'b1000, 1'b0);
    drive0(4'b1000, 1'b1);

    // Stall: lock, advance to 0100, then hold for 20 cycles before advancing.
    drive0(4'b0001, 1'b0);
    drive0(4'b0010, 1'b0);
    drive0(4'b0100, 1'b0);
    repeat (20) drive0(4'b0100, 1'b0);
    drive0(4'b1000, 1'b0);

    // More than 256 revolutions so the counter wraps.
    for (int i = 0; i < 1030; i++) drive0(4'(1 << (i % 4)), 1'b0);

    // Asynchronous reset mid-revolution: outputs clear with no clock edge.
    #2 clr = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    ring0 = '0; ring1 = '0; ec0 = 1'b0; ec1 = 1'b0;
    last[0] = '0; last[1] = '0;
    clr = 1'b1;

    // Randomized traffic on both instances.
    for (int i = 0; i < 2000; i++) cycle(gen(last[0], 0), rnd_clr(), gen(last[1], 1), rnd_clr());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
